xbar_pair_sched: RTL and testbench

//  Scheduler in front of the per-stage action crossbar. Buffers parsed PHVs and

---
 rtl/xbar_pair_sched.sv | 201 ++++++++++++++++++++
 tb/tb_xbar_pair_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_pair_sched.sv
// PHV/action pairing scheduler in front of the per-stage action crossbar.
// Optional statistics counters are built when XBAR_SCHED_STATS_EN is defined.

module xbar_pair_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = DEPTH + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

module xbar_pair_sched #(
  parameter int PHV_LEN    = 1124,
  parameter int ACT_LEN    = 25,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [PHV_LEN-1:0]      phv_in,
  input  logic                    phv_in_valid,
  output logic                    phv_in_ready,
  input  logic [ACT_LEN*25-1:0]   act_in,
  input  logic                    act_in_valid,
  input  logic                    act_hit,
  output logic                    act_in_ready,
  output logic [PHV_LEN-1:0]      xbar_phv,
  output logic                    xbar_phv_valid,
  output logic [ACT_LEN*25-1:0]   xbar_act,
  output logic                    xbar_act_valid,
  input  logic                    xbar_ready,
  output logic                    orphan_err
`ifdef XBAR_SCHED_STATS_EN
  ,
  output logic [31:0]             pair_cnt,
  output logic [31:0]             miss_cnt,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int ACT_W = ACT_LEN * 25;

  logic             phv_full;
  logic             phv_empty;
  logic             act_full;
  logic             act_empty;
  logic [PHV_LEN-1:0] phv_head;
  logic [ACT_W-1:0]   act_head;
  logic             phv_push;
  logic             act_accept;
  logic             act_orphan;
  logic             act_push;
  logic [ACT_W-1:0] act_wdata;
  logic             issue;
  logic             out_valid;

  always_comb begin
    phv_in_ready = !phv_full;
    act_in_ready = !act_full;
    phv_push     = phv_in_valid && phv_in_ready;
    act_accept   = act_in_valid && act_in_ready;
    // An action with no PHV buffered or arriving alongside it can never pair.
    act_orphan   = act_accept && phv_empty && !phv_push;
    act_push     = act_accept && !act_orphan;
    act_wdata    = act_hit ? act_in : '0;
    issue        = !phv_empty && !act_empty && (!out_valid || xbar_ready);
  end

  xbar_pair_sched_fifo #(
    .WIDTH (PHV_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_phv_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (phv_push),
    .wdata (phv_in),
    .pop   (issue),
    .rdata (phv_head),
    .full  (phv_full),
    .empty (phv_empty)
  );

  xbar_pair_sched_fifo #(
    .WIDTH (ACT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_act_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (act_push),
    .wdata (act_wdata),
    .pop   (issue),
    .rdata (act_head),
    .full  (act_full),
    .empty (act_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xbar_phv  <= '0;
      xbar_act  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      xbar_phv  <= phv_head;
      xbar_act  <= act_head;
      out_valid <= 1'b1;
    end else if (xbar_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign xbar_phv_valid = out_valid;
  assign xbar_act_valid = out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orphan_err <= 1'b0;
    end else if (flush) begin
      orphan_err <= 1'b0;
    end else if (act_orphan) begin
      orphan_err <= 1'b1;
    end
  end

`ifdef XBAR_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt  <= '0;
      miss_cnt  <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      pair_cnt  <= '0;
      miss_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue && (pair_cnt != '1)) begin
        pair_cnt <= pair_cnt + 32'd1;
      end
      if (act_accept && !act_hit && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
      if (out_valid && !xbar_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_xbar_pair_sched.sv
// Scoreboard bench for xbar_pair_sched; stats checks compile in with XBAR_SCHED_STATS_EN.

module tb_xbar_pair_sched;

  localparam int PHV_LEN = 1124;
  localparam int ACT_LEN = 25;
  localparam int ACT_W   = ACT_LEN * 25;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic [PHV_LEN-1:0] phv_in;
  logic               phv_in_valid;
  logic               phv_in_ready;
  logic [ACT_W-1:0]   act_in;
  logic               act_in_valid;
  logic               act_hit;
  logic               act_in_ready;
  logic [PHV_LEN-1:0] xbar_phv;
  logic               xbar_phv_valid;
  logic [ACT_W-1:0]   xbar_act;
  logic               xbar_act_valid;
  logic               xbar_ready;
  logic               orphan_err;
`ifdef XBAR_SCHED_STATS_EN
  logic [31:0]        pair_cnt;
  logic [31:0]        miss_cnt;
  logic [31:0]        stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;
  bit orphan_expected = 1'b0;

  logic [PHV_LEN-1:0] phv_q [$];
  logic [ACT_W-1:0]   act_q [$];

  always #5 clk = ~clk;

  xbar_pair_sched #(
    .PHV_LEN    (PHV_LEN),
    .ACT_LEN    (ACT_LEN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .phv_in         (phv_in),
    .phv_in_valid   (phv_in_valid),
    .phv_in_ready   (phv_in_ready),
    .act_in         (act_in),
    .act_in_valid   (act_in_valid),
    .act_hit        (act_hit),
    .act_in_ready   (act_in_ready),
    .xbar_phv       (xbar_phv),
    .xbar_phv_valid (xbar_phv_valid),
    .xbar_act       (xbar_act),
    .xbar_act_valid (xbar_act_valid),
    .xbar_ready     (xbar_ready),
    .orphan_err     (orphan_err)
`ifdef XBAR_SCHED_STATS_EN
    ,
    .pair_cnt       (pair_cnt),
    .miss_cnt       (miss_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [PHV_LEN-1:0] got,
                       input logic [PHV_LEN-1:0] exp);
    int idx;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      idx = -1;
      for (int i = PHV_LEN - 1; i >= 0; i--) begin
        if (got[i] !== exp[i]) idx = i;
      end
      $display("FAIL %s: got=%h exp=%h (low 64 bits, first differing bit %0d)",
               tag, got[63:0], exp[63:0], idx);
    end
  endtask

  function automatic logic [PHV_LEN-1:0] rnd_phv();
    logic [PHV_LEN-1:0] r = '0;
    for (int i = 0; i < (PHV_LEN + 31) / 32; i++) r = {r[PHV_LEN-33:0], $urandom()};
    return r;
  endfunction

  function automatic logic [ACT_W-1:0] rnd_act();
    logic [ACT_W-1:0] r = '0;
    for (int i = 0; i < (ACT_W + 31) / 32; i++) r = {r[ACT_W-33:0], $urandom()};
    return r;
  endfunction

  // Scoreboard: accepted inputs are queued; every valid output cycle is compared to the heads.
  always @(negedge clk) begin
    if (!rst_n) begin
      phv_q.delete();
      act_q.delete();
      check("rst_phv_valid", xbar_phv_valid, 0);
      check("rst_xbar_phv", xbar_phv, 0);
      check("rst_xbar_act", xbar_act, 0);
      check("rst_orphan", orphan_err, 0);
    end else if (flush) begin
      phv_q.delete();
      act_q.delete();
    end else begin
      if (phv_in_valid && phv_in_ready) phv_q.push_back(phv_in);
      if (act_in_valid && act_in_ready && !orphan_expected)
        act_q.push_back(act_hit ? act_in : '0);
      if (xbar_phv_valid) begin
        check("model_has_pair", (phv_q.size() != 0) && (act_q.size() != 0), 1);
        check("act_valid_high", xbar_act_valid, 1);
        if ((phv_q.size() != 0) && (act_q.size() != 0)) begin
          check("xbar_phv", xbar_phv, phv_q[0]);
          check("xbar_act", xbar_act, act_q[0]);
          if (xbar_ready) begin
            void'(phv_q.pop_front());
            void'(act_q.pop_front());
            hs_cnt++;
          end
        end
      end else begin
        check("act_valid_low", xbar_act_valid, 0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_phv(input logic [PHV_LEN-1:0] d);
    bit done = 1'b0;
    phv_in = d;
    phv_in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (phv_in_ready) done = 1'b1;
    end
    check("phv_accept", done, 1);
    @(posedge clk); #1;
    phv_in_valid = 1'b0;
  endtask

  task automatic send_act(input logic [ACT_W-1:0] d, input logic hit);
    bit done = 1'b0;
    act_in = d;
    act_hit = hit;
    act_in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (act_in_ready) done = 1'b1;
    end
    check("act_accept", done, 1);
    @(posedge clk); #1;
    act_in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic hit);
    logic [PHV_LEN-1:0] p;
    logic [ACT_W-1:0]   a;
    p = rnd_phv();
    a = rnd_act();
    fork
      send_phv(p);
      send_act(a, hit);
    join
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (xbar_phv_valid) seen = 1'b1;
    end
    check("wait_valid", seen, 1);
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      if (!xbar_phv_valid && phv_q.size() == 0 && act_q.size() == 0) idle = 1'b1;
    end
    check("drain", idle, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int base;
    logic [PHV_LEN-1:0] p0;
    rst_n = 1'b0; flush = 1'b0;
    phv_in = '0; phv_in_valid = 1'b0;
    act_in = '0; act_in_valid = 1'b0; act_hit = 1'b0;
    xbar_ready = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_phv_ready", phv_in_ready, 1);
    check("rst_act_ready", act_in_ready, 1);
    check("idle_valid", xbar_phv_valid, 0);
    @(posedge clk); #1;

    // 1: pair in one cycle, valid two cycles later
    base = hs_cnt;
    phv_in = rnd_phv(); phv_in_valid = 1'b1;
    act_in = rnd_act(); act_hit = 1'b1; act_in_valid = 1'b1;
    @(posedge clk); #1;
    phv_in_valid = 1'b0; act_in_valid = 1'b0;
    @(negedge clk);
    check("lat_not_early", xbar_phv_valid, 0);
    @(negedge clk);
    check("lat_valid", xbar_phv_valid, 1);
    drain();
    check("t1_pairs", hs_cnt - base, 1);

    // 2: miss action arriving late becomes all-zero
    base = hs_cnt;
    send_phv(rnd_phv());
    repeat (4) @(posedge clk);
    #1;
    check("t2_no_early_pair", xbar_phv_valid, 0);
    send_act(rnd_act(), 1'b0);
    drain();
    check("t2_pairs", hs_cnt - base, 1);

    // 3: PHV FIFO fills, fifth held until space
    base = hs_cnt;
    for (int i = 0; i < DEPTH; i++) send_phv(rnd_phv());
    @(negedge clk);
    check("t3_phv_full", phv_in_ready, 0);
    check("t3_act_ready", act_in_ready, 1);
    @(posedge clk); #1;
    fork
      send_phv(rnd_phv());
      begin
        repeat (3) @(negedge clk);
        check("t3_still_full", phv_in_ready, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) send_act(rnd_act(), 1'b1);
      end
    join
    drain();
    check("t3_pairs", hs_cnt - base, 5);

    // 4: downstream stall holds outputs; next pair follows release
    base = hs_cnt;
    xbar_ready = 1'b0;
    send_pair(1'b1);
    send_pair(1'b1);
    wait_valid();
    p0 = xbar_phv;
    repeat (3) @(negedge clk);
    check("t4_no_hs", hs_cnt - base, 0);
    @(posedge clk); #1;
    xbar_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_next_valid", xbar_phv_valid, 1);
    check("t4_next_differs", (xbar_phv != p0), 1);
    drain();
    check("t4_pairs", hs_cnt - base, 2);

    // Throughput: back-to-back pairs keep valid high every cycle
    fork
      for (int i = 0; i < 6; i++) send_pair(1'b1);
      begin
        wait_valid();
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("tput_valid", xbar_phv_valid, 1);
        end
      end
    join
    drain();

    // 5: orphan action, then flush clears everything
    base = hs_cnt;
    orphan_expected = 1'b1;
    send_act(rnd_act(), 1'b1);
    orphan_expected = 1'b0;
    @(negedge clk);
    check("t5_orphan_set", orphan_err, 1);
    send_phv(rnd_phv());
    send_phv(rnd_phv());
    repeat (2) @(negedge clk);
    check("t5_no_output", xbar_phv_valid, 0);
    check("t5_orphan_sticky", orphan_err, 1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t5_orphan_clr", orphan_err, 0);
    check("t5_phv_ready", phv_in_ready, 1);
    @(posedge clk); #1;
    send_pair(1'b1);
    drain();
    check("t5_pairs", hs_cnt - base, 1);

    // Reset mid-operation drops in-flight pairs
    base = hs_cnt;
    xbar_ready = 1'b0;
    send_pair(1'b1);
    send_pair(1'b1);
    xbar_ready = 1'b1;
    do_reset();
    @(negedge clk);
    check("mid_rst_valid", xbar_phv_valid, 0);
    check("mid_rst_ready", phv_in_ready, 1);
    @(posedge clk); #1;
    send_pair(1'b0);
    drain();
    check("mid_rst_pairs", hs_cnt - base, 1);

`ifdef XBAR_SCHED_STATS_EN
    // 6: statistics counters from a clean reset
    do_reset();
    xbar_ready = 1'b0;
    send_pair(1'b1);
    wait_valid();
    repeat (3) @(posedge clk);
    #1 xbar_ready = 1'b1;
    for (int i = 1; i < 10; i++) send_pair((i == 3 || i == 7) ? 1'b0 : 1'b1);
    drain();
    check("pair_cnt", pair_cnt, 10);
    check("miss_cnt", miss_cnt, 2);
    check("stall_cnt", stall_cnt, 3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("pair_cnt_flush", pair_cnt, 0);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
